// File: rtl/mem_access_stage_if.sv
// Data-memory request bus between the memory stage (master) and data memory (slave).
// A request is valid while dm_req is high and completes on the cycle dm_ready is high.
interface mem_access_stage_if #(
  parameter int unsigned N = 64
);
  logic         dm_req;
  logic         dm_we;
  logic [N-1:0] dm_addr;
  logic [N-1:0] dm_wdata;
  logic         dm_ready;
  logic [N-1:0] dm_rdata;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_ready,
    input  dm_rdata
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_ready,
    output dm_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage: runs LDUR/STUR against a variable-latency data memory, stalling upstream meanwhile.
// Optional MISALIGN_TRAP_EN: misaligned ops skip the bus and pulse misalign_M instead.
module mem_access_stage #(
  parameter int unsigned N       = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memRead_M,
  input  logic                      memWrite_M,
  input  logic [N-1:0]              address_M,
  input  logic [N-1:0]              writeData_M,
  mem_access_stage_if.master        dm,
  output logic [N-1:0]              readData_M,
  output logic                      stall_M,
  output logic                      bus_err,
  output logic                      misalign_M
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    addr_q, addr_d;
  logic [N-1:0]    wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [N-1:0]    rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            op_valid;
  logic            trap;

  assign op_valid = memRead_M | memWrite_M;

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  assign trap       = op_valid & (address_M[2:0] != 3'b000);
  assign misalign_M = (state_q == StDone) & mis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
`else
  assign trap       = 1'b0;
  assign misalign_M = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
`ifdef MISALIGN_TRAP_EN
          mis_d = trap;
`endif
          if (trap) begin
            state_d = StDone;
          end else begin
            addr_d  = address_M;
            wdata_d = writeData_M;
            we_d    = memWrite_M;  // read+write together is a write
            cnt_d   = '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (dm.dm_ready) begin
          if (!we_q) rdata_d = dm.dm_rdata;
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          err_d = 1'b1;
          if (!we_q) rdata_d = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;  // op inputs here belong to the finished instruction
      default: state_d = StIdle;
    endcase
  end

  assign dm.dm_req   = (state_q == StReq);
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign readData_M  = rdata_q;
  assign bus_err     = err_q;
  // Gated by reset so the stall releases the instant reset asserts.
  assign stall_M     = reset & (((state_q == StIdle) & op_valid) | (state_q == StReq));

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage placed directly downstream of execute. Consumes execute's ALU result (address) and store data (writeData).
- Runs LDUR/STUR accesses against a data memory with variable latency, using a req/ready handshake.
- Holds `stall_M` high while an access is outstanding, which freezes PC and upstream state. Presents load data to writeback.

Parameters:
- N, 64, datapath/address width
- TIMEOUT, 16, max cycles in REQ waiting for dm_ready before abort (>=2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- memRead_M  in  1  load request for current instruction
- memWrite_M  in  1  store request for current instruction
- address_M  in  N  effective address (execute ALU result)
- writeData_M  in  N  store data (execute writeData)
- dm_req  out  1  data-memory request valid
- dm_we  out  1  1=write, 0=read, valid with dm_req
- dm_addr  out  N  latched address
- dm_wdata  out  N  latched store data
- dm_ready  in  1  memory completes request this cycle (sampled only while dm_req=1)
- dm_rdata  in  N  read data, valid when dm_ready=1 and dm_we=0
- readData_M  out  N  load result to writeback
- stall_M  out  1  freeze PC/upstream
- bus_err  out  1  sticky timeout flag
- misalign_M  out  1  misaligned-access pulse (see Optional Feature)

Behaviour:

Reset (reset=0, takes effect immediately):
- State=IDLE; dm_req, dm_we, stall_M, bus_err and misalign_M all 0.
- dm_addr, dm_wdata, readData_M and the timeout counter all 0.
- Reset during REQ drops dm_req at once. No completion is reported.

States:
- IDLE:
  - stall_M = memRead_M | memWrite_M (combinational, same cycle).
  - If either is set: latch address_M into dm_addr and writeData_M into dm_wdata.
  - dm_we latch = memWrite_M. Clear counter, go REQ.
  - Else stay IDLE.
- REQ:
  - dm_req=1 and stall_M=1; dm_addr/dm_wdata/dm_we are stable and come from the latches.
  - dm_ready=1:
    - Read: readData_M <= dm_rdata.
    - Either way: go DONE.
  - Else, counter == TIMEOUT-1: bus_err <= 1; on read, readData_M <= 0; go DONE.
  - Else counter++.
- DONE:
  - stall_M=0 and dm_req=0; the pipeline advances on this edge.
  - Unconditionally go IDLE. The op inputs seen in DONE belong to the completed instruction and are ignored.

Timing and data rules:
- Minimum access: 3 cycles (IDLE, REQ with immediate ready, DONE), of which stall_M is high for 2.
- Latency with ready after k REQ cycles: k+2.
- memRead_M and memWrite_M both high: treated as a write; readData_M is unchanged.
- readData_M holds its value until the next completed read; stores never modify it.
- dm_ready outside REQ: ignored.
- bus_err: sticky, cleared only by reset.
- Counter: $clog2(TIMEOUT) bits, no wrap beyond TIMEOUT-1.

Optional Feature:
- Macro: MISALIGN_TRAP_EN
- Defined:
  - In IDLE, an op with address_M[2:0] != 0 issues no bus request.
  - FSM goes straight to DONE. misalign_M=1 for that DONE cycle only.
  - readData_M is unchanged; stall_M is high for 1 cycle.
- Undefined:
  - misalign_M is tied 0.
  - All addresses go to the bus unmodified, low bits included.

Test Plan:
1. Load, ready on 1st REQ cycle: address_M=0x40, memRead_M=1, dm_rdata=0xDEADBEEF00000001 -> dm_req high 1 cycle with dm_addr=0x40, dm_we=0; stall_M high 2 cycles; readData_M=0xDEADBEEF00000001 in DONE.
2. Store, ready after 4 REQ cycles: address_M=0x80, writeData_M=0x1234, memWrite_M=1 -> dm_we=1, dm_wdata=0x1234 stable for 4 cycles; stall_M high 5 cycles; readData_M unchanged.
3. Timeout: load with dm_ready held 0, TIMEOUT=16 -> dm_req high exactly 16 cycles; bus_err=1 and stays 1; readData_M=0; stall_M drops in DONE.
4. Reset mid-access: drive reset=0 during REQ cycle 2 -> dm_req and stall_M go 0 before the next clk edge; after release, state IDLE; a new load completes normally.
5. Simultaneous memRead_M=memWrite_M=1, address 0x10 -> single write request (dm_we=1); readData_M keeps prior value 0x55.
6. With MISALIGN_TRAP_EN, load at 0x43 -> no dm_req; stall_M high 1 cycle; misalign_M pulses 1 cycle. Without the macro: normal request with dm_addr=0x43.
